// File: rtl/l2_arb_pkg.sv
// ============================================================================
// Module      : l2_arb_pkg
// Description : Shared types for the L2 request arbiter (FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_arb_pkg;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DLVR = 2'd3
  } arb_state_e;

endpackage : l2_arb_pkg

`default_nettype wire

// File: rtl/l2_req_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first requester at or after
//               ptr_i (wrapping) wins. Outputs one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] oh_o,
  output logic [PTR_W-1:0]   idx_o
);

  // Scan from the farthest offset down so the nearest requester overrides.
  always_comb begin
    idx_o = '0;
    oh_o  = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N_PORTS]) begin
        idx_o = PTR_W'((int'(ptr_i) + k) % N_PORTS);
      end
    end
    if (|req_i) begin
      oh_o[idx_o] = 1'b1;
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/l2_req_arbiter.sv
// ============================================================================
// Module      : l2_req_arbiter
// Description : N-port round-robin front end of the L2 cache. One transaction
//               at a time; grant held until the client signals completion.
//               Optional watchdog enabled by macro L2_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_i,
  input  logic [N_PORTS-1:0]          rw_i,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [N_PORTS*LINE_W-1:0]   wd_i,
  input  logic [N_PORTS-1:0]          complete_i,
  output logic [N_PORTS-1:0]          grant_o,
  output logic [LINE_W-1:0]           rd_o,
  output logic [N_PORTS-1:0]          rd_vld_o,
  output logic                        l2_req_o,
  input  logic                        l2_ack_i,
  output logic [ADDR_W-1:0]           l2_addr_o,
  output logic                        l2_rw_o,
  output logic [LINE_W-1:0]           l2_wd_o,
  input  logic                        l2_rdy_i,
  input  logic [LINE_W-1:0]           l2_rd_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [N_PORTS-1:0] w_pick_oh;
  logic [N_PORTS-1:0] w_gnt_oh;
  logic               w_pick_vld;
  logic               w_timeout;
  logic               w_release;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rw;
  logic [LINE_W-1:0]  r_wd;
  logic [LINE_W-1:0]  r_rd;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (r_ptr),
    .oh_o  (w_pick_oh),
    .idx_o (w_pick_idx)
  );

  assign w_pick_vld = |w_pick_oh;

  always_comb begin
    w_gnt_oh         = '0;
    w_gnt_oh[r_gidx] = 1'b1;
  end

  assign w_ptr_nxt = (r_gidx == PTR_W'(N_PORTS - 1)) ? '0 : r_gidx + PTR_W'(1);

  assign grant_o   = (r_state != IDLE) ? w_gnt_oh : '0;
  assign rd_vld_o  = (r_state == DLVR) ? w_gnt_oh : '0;
  assign l2_req_o  = (r_state == REQ);
  assign busy_o    = (r_state != IDLE);
  assign l2_addr_o = r_addr;
  assign l2_rw_o   = r_rw;
  assign l2_wd_o   = r_wd;
  assign rd_o      = r_rd;
  assign err_o     = w_timeout;

`ifdef L2_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_in_wd;

  assign w_in_wd = (r_state == REQ) || (r_state == WAIT);

  // A genuine ack/rdy in the final cycle beats the watchdog.
  assign w_timeout = w_in_wd && (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                     !((r_state == REQ && l2_ack_i) || (r_state == WAIT && l2_rdy_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_in_wd) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC == 0);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) w_next = REQ;
      end
      REQ: begin
        if (l2_ack_i) begin
          w_next = WAIT;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_release = 1'b1;
        end
      end
      WAIT: begin
        if (l2_rdy_i) begin
          w_next = DLVR;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_release = 1'b1;
        end
      end
      DLVR: begin
        if (complete_i[r_gidx]) begin
          w_next    = IDLE;
          w_release = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wd    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_pick_vld) begin
        r_gidx <= w_pick_idx;
        r_addr <= addr_i[w_pick_idx*ADDR_W +: ADDR_W];
        r_rw   <= rw_i[w_pick_idx];
        r_wd   <= wd_i[w_pick_idx*LINE_W +: LINE_W];
      end
      // Writes return only an ack; keep the last read line visible.
      if (r_state == WAIT && l2_rdy_i && !r_rw) begin
        r_rd <= l2_rd_i;
      end
      if (w_release) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule : l2_req_arbiter

`default_nettype wire

// File: tb/tb_l2_req_arbiter.sv
// ============================================================================
// Module      : tb_l2_req_arbiter
// Description : Directed self-checking bench for l2_req_arbiter (4 ports).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, rw, complete, grant, rd_vld;
  logic [N*AW-1:0] addr;
  logic [N*LW-1:0] wd;
  logic [LW-1:0]   rd, l2_wd, l2_rd;
  logic [AW-1:0]   l2_addr;
  logic            l2_req, l2_ack, l2_rw, l2_rdy, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] a_tab [N];
  logic [LW-1:0] last_rd;

  always #5 clk = ~clk;

  l2_req_arbiter #(
    .N_PORTS     (N),
    .ADDR_W      (AW),
    .LINE_W      (LW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .rw_i       (rw),
    .addr_i     (addr),
    .wd_i       (wd),
    .complete_i (complete),
    .grant_o    (grant),
    .rd_o       (rd),
    .rd_vld_o   (rd_vld),
    .l2_req_o   (l2_req),
    .l2_ack_i   (l2_ack),
    .l2_addr_o  (l2_addr),
    .l2_rw_o    (l2_rw),
    .l2_wd_o    (l2_wd),
    .l2_rdy_i   (l2_rdy),
    .l2_rd_i    (l2_rd),
    .busy_o     (busy),
    .err_o      (err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    a_tab[0] = 32'h0000_0100;
    a_tab[1] = 32'h0000_1F40;
    a_tab[2] = 32'h0000_2000;
    a_tab[3] = 32'h0000_3000;
    for (int p = 0; p < N; p++) begin
      addr[p*AW +: AW] = a_tab[p];
      wd[p*LW +: LW]   = {4{32'h1111_0000 + p}};
    end
    wd[0 +: LW] = {4{32'hDEAD_BEEF}};
    rst = 1'b0; req = '0; rw = '0; complete = '0;
    l2_ack = 1'b0; l2_rdy = 1'b0; l2_rd = '0;
    cyc(); cyc();

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_l2req", l2_req, 0);
    check("rst_rdvld", rd_vld, 0);
    check("rst_addr", l2_addr, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    cyc();

    // Port 1 read
    req = 4'b0010;
    cyc();
    check("rd_grant", grant, 4'b0010);
    check("rd_l2req", l2_req, 1);
    check("rd_addr", l2_addr, 32'h0000_1F40);
    check("rd_rw", l2_rw, 0);
    check("rd_busy", busy, 1);
    req = '0; l2_ack = 1'b1;
    cyc();
    check("rd_wait_l2req", l2_req, 0);
    check("rd_wait_vld", rd_vld, 0);
    l2_ack = 1'b0; l2_rdy = 1'b1; l2_rd = {16{8'hA5}};
    cyc();
    l2_rdy = 1'b0; l2_rd = '0;
    check("rd_data", rd, {16{8'hA5}});
    check("rd_vld", rd_vld, 4'b0010);
    cyc();
    check("rd_hold_data", rd, {16{8'hA5}});
    check("rd_hold_vld", rd_vld, 4'b0010);
    check("rd_hold_grant", grant, 4'b0010);
    complete = 4'b0010;
    cyc();
    complete = '0;
    check("rd_done_grant", grant, 0);
    check("rd_done_busy", busy, 0);

    // Reset in the middle of WAIT (rr_ptr is 2 here)
    req = 4'b0100;
    cyc();
    check("mr_grant", grant, 4'b0100);
    req = '0; l2_ack = 1'b1;
    cyc();
    l2_ack = 1'b0;
    cyc();
    check("mr_busy_wait", busy, 1);
    rst = 1'b0;
    #1;
    check("mr_grant0", grant, 0);
    check("mr_busy0", busy, 0);
    check("mr_l2req0", l2_req, 0);
    check("mr_addr0", l2_addr, 0);
    check("mr_rdvld0", rd_vld, 0);
    cyc();
    rst = 1'b1;

    // All ports requesting: 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rr_grant", grant, 4'b0001 << (k % N));
      check("rr_addr", l2_addr, a_tab[k % N]);
      l2_ack = 1'b1;
      cyc();
      l2_ack = 1'b0; l2_rdy = 1'b1; l2_rd = {4{32'hC0DE_0000 + k}};
      cyc();
      l2_rdy = 1'b0;
      check("rr_vld", rd_vld, 4'b0001 << (k % N));
      check("rr_data", rd, {4{32'hC0DE_0000 + k}});
      complete = 4'b0001 << (k % N);
      cyc();
      complete = '0;
      check("rr_idle_gap", grant, 0);
    end
    req = '0;
    last_rd = {4{32'hC0DE_0004}};

    // Port 0 write with delayed ack (rr_ptr is 1: scan wraps to 0)
    rw  = 4'b0001;
    req = 4'b0001;
    cyc();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      check("wr_l2req", l2_req, 1);
      check("wr_addr", l2_addr, a_tab[0]);
      check("wr_wd", l2_wd, {4{32'hDEAD_BEEF}});
      check("wr_rw", l2_rw, 1);
      if (i < 4) cyc();
    end
    l2_ack = 1'b1; l2_rdy = 1'b1; l2_rd = {4{32'hBAD0_BAD0}};
    cyc();
    l2_ack = 1'b0;
    check("wr_ackrdy_vld", rd_vld, 0);
    check("wr_ackrdy_busy", busy, 1);
    check("wr_ackrdy_l2req", l2_req, 0);
    cyc();
    l2_rdy = 1'b0; l2_rd = '0;
    check("wr_ack_vld", rd_vld, 4'b0001);
    check("wr_rd_unchanged", rd, last_rd);
    complete = 4'b0001;
    cyc();
    complete = '0; rw = '0;
    check("wr_done_grant", grant, 0);

    // req drop in WAIT and spurious complete on port 1 (rr_ptr is 1)
    req = 4'b0001;
    cyc();
    check("sp_grant", grant, 4'b0001);
    l2_ack = 1'b1;
    cyc();
    l2_ack = 1'b0; req = '0; complete = 4'b0010;
    cyc();
    complete = '0;
    check("sp_wait_busy", busy, 1);
    check("sp_wait_grant", grant, 4'b0001);
    check("sp_wait_vld", rd_vld, 0);
    l2_rdy = 1'b1;
    cyc();
    l2_rdy = 1'b0; complete = 4'b0010;
    check("sp_dlvr_vld", rd_vld, 4'b0001);
    cyc();
    check("sp_dlvr_hold", rd_vld, 4'b0001);
    complete = 4'b0001;
    cyc();
    complete = '0;
    check("sp_done_busy", busy, 0);

    // ack/rdy while IDLE are ignored
    l2_ack = 1'b1; l2_rdy = 1'b1;
    cyc();
    l2_ack = 1'b0; l2_rdy = 1'b0;
    check("idle_ign_busy", busy, 0);
    check("idle_ign_vld", rd_vld, 0);

    // Watchdog (rr_ptr is 1)
    req = 4'b0011;
    cyc();
    check("wd_grant", grant, 4'b0010);
    l2_ack = 1'b1;
    cyc();
    l2_ack = 1'b0;
`ifdef L2_ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      check("wd_err_low", err, 0);
      cyc();
    end
    check("wd_err_pulse", err, 1);
    check("wd_busy_last", busy, 1);
    check("wd_vld_last", rd_vld, 0);
    cyc();
    check("wd_err_clear", err, 0);
    check("wd_released", grant, 0);
    cyc();
    check("wd_next_grant", grant, 4'b0001);
    req = '0; l2_ack = 1'b1;
    cyc();
    l2_ack = 1'b0; l2_rdy = 1'b1;
    cyc();
    l2_rdy = 1'b0; complete = 4'b0001;
    cyc();
    complete = '0;
    check("wd_end_busy", busy, 0);
`else
    for (int i = 0; i < 20; i++) cyc();
    check("nowd_err", err, 0);
    check("nowd_busy", busy, 1);
    check("nowd_grant", grant, 4'b0010);
    req = '0; l2_rdy = 1'b1;
    cyc();
    l2_rdy = 1'b0; complete = 4'b0010;
    check("nowd_vld", rd_vld, 4'b0010);
    cyc();
    complete = '0;
    check("nowd_end_busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_l2_req_arbiter

`default_nettype wire
